// File: rtl/mopshub_pkg.sv
// Shared MOPS-Hub types: CAN frame width, bus ID width and the uplink frame record.
package mopshub_pkg;

    localparam int CAN_FRAME_W = 76;
    localparam int BUS_ID_W    = 5;
    localparam int FRAME_W     = BUS_ID_W + CAN_FRAME_W;

    typedef struct packed {
        logic [BUS_ID_W-1:0]    bus_id;
        logic [CAN_FRAME_W-1:0] data;
    } uplink_frame_t;

endpackage

// File: rtl/mopshub_fifo_mem.sv
// Frame storage for the uplink buffer: one synchronous write port and one asynchronous read port.
module mopshub_fifo_mem
    import mopshub_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  uplink_frame_t i_wdata,
    input  logic [AW-1:0] i_raddr,
    output uplink_frame_t o_rdata
);

    uplink_frame_t r_mem [DEPTH];

    // Storage array: contents are qualified by the pointers, so they carry no reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mopshub_uplink_buffer.sv
// Uplink frame buffer between the CAN receive path and the elink transmitter.
// First-word-fall-through FIFO with registered head, fill/full flags, overflow counter and arrival irq.
module mopshub_uplink_buffer
    import mopshub_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int OVF_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     irq_can_rec,
    input  logic [CAN_FRAME_W-1:0]   data_rec_uplink,
    input  logic [BUS_ID_W-1:0]      can_rec_select,
    input  logic                     flush,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [CAN_FRAME_W-1:0]   data_o,
    output logic [BUS_ID_W-1:0]      bus_id_o,
    output logic                     irq_elink_rec,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     full,
    output logic [OVF_W-1:0]         overflow_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [AW:0]       w_wr_ptr_nxt;
    logic [AW:0]       w_rd_ptr_nxt;
    logic [AW:0]       w_fill_nxt;
    logic              w_full_nxt;
    logic              w_valid_nxt;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_drop;
    uplink_frame_t     w_frame_in;
    uplink_frame_t     w_mem_rdata;
    uplink_frame_t     w_head;

    logic              r_valid;
    logic              r_irq;
    logic              r_full;
    logic [AW:0]       r_fill;
    logic [OVF_W-1:0]  r_ovf;
    uplink_frame_t     r_head;

    assign w_frame_in = {can_rec_select, data_rec_uplink};

    mopshub_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (w_frame_in),
        .i_raddr (w_rd_ptr_nxt[AW-1:0]),
        .o_rdata (w_mem_rdata)
    );

    // Next-state pointers, flags and head frame; flush overrides any transfer in the same cycle.
    always_comb begin
        w_wr_en      = irq_can_rec & ~r_full & ~flush;
        w_rd_en      = r_valid & ready_i & ~flush;
        w_drop       = irq_can_rec & r_full & ~flush;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end else begin
            if (w_wr_en) begin
                w_wr_ptr_nxt = r_wr_ptr + (AW+1)'(1);
            end else begin
                w_wr_ptr_nxt = r_wr_ptr;
            end
            if (w_rd_en) begin
                w_rd_ptr_nxt = r_rd_ptr + (AW+1)'(1);
            end else begin
                w_rd_ptr_nxt = r_rd_ptr;
            end
        end
        w_valid_nxt = (w_wr_ptr_nxt != w_rd_ptr_nxt);
        w_full_nxt  = (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]) &&
                      (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]);
        w_fill_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
        // The next head is the slot being written right now: bypass the array.
        if (w_wr_en && (w_rd_ptr_nxt == r_wr_ptr)) begin
            w_head = w_frame_in;
        end else begin
            w_head = w_mem_rdata;
        end
    end

    // Pointer, flag, head, overflow and irq registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= 1'b0;
            r_irq    <= 1'b0;
            r_full   <= 1'b0;
            r_fill   <= '0;
            r_ovf    <= '0;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_valid  <= w_valid_nxt;
            r_irq    <= ~r_valid & w_valid_nxt;
            r_full   <= w_full_nxt;
            r_fill   <= w_fill_nxt;
            if (w_drop && (r_ovf != {OVF_W{1'b1}})) begin
                r_ovf <= r_ovf + OVF_W'(1);
            end else begin
                r_ovf <= r_ovf;
            end
            // Holding the old head while empty keeps the outputs free of unwritten memory.
            if (w_valid_nxt) begin
                r_head <= w_head;
            end else begin
                r_head <= r_head;
            end
        end
    end

    assign valid_o       = r_valid;
    assign data_o        = r_head.data;
    assign bus_id_o      = r_head.bus_id;
    assign irq_elink_rec = r_irq;
    assign fill_level    = r_fill;
    assign full          = r_full;
    assign overflow_cnt  = r_ovf;

endmodule

// File: tb/tb_mopshub_uplink_buffer.sv
// Scoreboard bench for mopshub_uplink_buffer: frames queued on accepted writes, popped on reads.
module tb_mopshub_uplink_buffer;

    localparam int DEPTH = 8;
    localparam int OVF_W = 8;

    logic         clk;
    logic         rst;
    logic         irq_can_rec;
    logic [75:0]  data_rec_uplink;
    logic [4:0]   can_rec_select;
    logic         flush;
    logic         ready_i;
    logic         valid_o;
    logic [75:0]  data_o;
    logic [4:0]   bus_id_o;
    logic         irq_elink_rec;
    logic [3:0]   fill_level;
    logic         full;
    logic [7:0]   overflow_cnt;

    int           n_vec;
    int           n_err;
    logic [80:0]  sb_q [$];
    logic         m_valid;
    logic [7:0]   m_ovf;

    mopshub_uplink_buffer #(
        .DEPTH (DEPTH),
        .OVF_W (OVF_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .irq_can_rec     (irq_can_rec),
        .data_rec_uplink (data_rec_uplink),
        .can_rec_select  (can_rec_select),
        .flush           (flush),
        .ready_i         (ready_i),
        .valid_o         (valid_o),
        .data_o          (data_o),
        .bus_id_o        (bus_id_o),
        .irq_elink_rec   (irq_elink_rec),
        .fill_level      (fill_level),
        .full            (full),
        .overflow_cnt    (overflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, update the model across the edge, then check the flags.
    task automatic cycle(input logic irq, input logic [75:0] d, input logic [4:0] b,
                         input logic rdy, input logic fl);
        logic [80:0] f;
        int          sz;
        logic        prev_valid;
        irq_can_rec     = irq;
        data_rec_uplink = d;
        can_rec_select  = b;
        ready_i         = rdy;
        flush           = fl;
        sz = sb_q.size();
        if (!fl && m_valid && rdy) begin
            f = sb_q.pop_front();
            check_value("rd_frame", {15'd0, bus_id_o, data_o}, {15'd0, f});
        end
        if (!fl && irq) begin
            if (sz < DEPTH) sb_q.push_back({b, d});
            else if (m_ovf != 8'hFF) m_ovf = m_ovf + 8'd1;
        end
        if (fl) sb_q.delete();
        @(posedge clk);
        #1;
        prev_valid = m_valid;
        m_valid    = (sb_q.size() != 0);
        check_value("fill_level", {92'd0, fill_level}, 96'(sb_q.size()));
        check_value("valid_o", {95'd0, valid_o}, {95'd0, m_valid});
        check_value("full", {95'd0, full}, {95'd0, (sb_q.size() == DEPTH)});
        check_value("irq_elink_rec", {95'd0, irq_elink_rec}, {95'd0, (~prev_valid & m_valid)});
        check_value("overflow_cnt", {88'd0, overflow_cnt}, {88'd0, m_ovf});
        irq_can_rec = 1'b0;
        ready_i     = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 76'd0, 5'd0, 1'b1, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_valid"}, {95'd0, valid_o}, 96'd0);
        check_value({tag, "_data"}, {20'd0, data_o}, 96'd0);
        check_value({tag, "_bus"}, {91'd0, bus_id_o}, 96'd0);
        check_value({tag, "_irq"}, {95'd0, irq_elink_rec}, 96'd0);
        check_value({tag, "_fill"}, {92'd0, fill_level}, 96'd0);
        check_value({tag, "_full"}, {95'd0, full}, 96'd0);
        check_value({tag, "_ovf"}, {88'd0, overflow_cnt}, 96'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_valid = 1'b0;
        m_ovf = 8'd0;
        rst = 1'b1;
        irq_can_rec = 1'b0;
        data_rec_uplink = 76'd0;
        can_rec_select = 5'd0;
        flush = 1'b0;
        ready_i = 1'b0;
        #1 rst = 1'b0;
        #2 check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // Single frame into an empty buffer with the transmitter stalled.
        cycle(1'b1, 76'hA5, 5'd3, 1'b0, 1'b0);
        check_value("first_data", {20'd0, data_o}, 96'hA5);
        check_value("first_bus", {91'd0, bus_id_o}, 96'd3);
        cycle(1'b0, 76'd0, 5'd0, 1'b0, 1'b0);
        drain();

        // Ten frames into eight slots: two dropped, 1..8 drained in order.
        for (int i = 1; i <= 10; i++) cycle(1'b1, 76'(i), 5'(i), 1'b0, 1'b0);
        check_value("ovf_after_10", {88'd0, overflow_cnt}, 96'd2);
        drain();

        // Steady state at four frames with a write and a read every cycle.
        for (int i = 0; i < 4; i++) cycle(1'b1, 76'(100 + i), 5'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, {44'hC0FFEE, 32'($urandom)}, 5'($urandom_range(31, 0)), 1'b1, 1'b0);
            check_value("steady_fill", {92'd0, fill_level}, 96'd4);
        end
        drain();

        // Write into an empty buffer while ready is already high.
        cycle(1'b1, 76'h1234_5678_9ABC, 5'd17, 1'b1, 1'b0);
        cycle(1'b0, 76'd0, 5'd0, 1'b1, 1'b0);
        cycle(1'b0, 76'd0, 5'd0, 1'b1, 1'b0);

        // Flush with five frames stored; the concurrent write and read are discarded.
        for (int i = 0; i < 5; i++) cycle(1'b1, 76'(200 + i), 5'(i + 8), 1'b0, 1'b0);
        cycle(1'b1, 76'hDEAD, 5'd9, 1'b1, 1'b1);
        check_value("flush_ovf", {88'd0, overflow_cnt}, 96'd2);
        cycle(1'b1, 76'hBEEF, 5'd10, 1'b0, 1'b0);
        drain();

        // Overflow saturation, then asynchronous reset in the middle of a drain.
        for (int i = 0; i < 300; i++) cycle(1'b1, 76'(1000 + i), 5'(i), 1'b0, 1'b0);
        check_value("ovf_saturated", {88'd0, overflow_cnt}, 96'd255);
        cycle(1'b0, 76'd0, 5'd0, 1'b1, 1'b0);
        cycle(1'b0, 76'd0, 5'd0, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1 check_all_zero("async_rst");
        sb_q.delete();
        m_valid = 1'b0;
        m_ovf = 8'd0;
        @(posedge clk);
        #1 rst = 1'b1;
        cycle(1'b0, 76'd0, 5'd0, 1'b1, 1'b0);
        cycle(1'b1, 76'h77, 5'd7, 1'b0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
